debug_unit: RTL

DEBUG_UNIT -- requirements
Module: debug_unit

---
 rtl/debug_pkg.sv | 26 ++
 rtl/report_tx.sv | 76 +++++++
 rtl/debug_unit.sv | 99 +++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared definitions for the debug unit: host command codes, FSM state encoding
// and report framing. Also imported by host-link testbenches.
package debug_pkg;

  localparam logic [7:0] CMD_CONT   = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP   = 8'h73;  // 's'
  localparam logic [7:0] CMD_REPORT = 8'h72;  // 'r'
  localparam logic [7:0] CMD_HALT   = 8'h68;  // 'h'

  // Index of the last byte of a report (PC, count high, count low).
  localparam logic [1:0] REPORT_LAST_IDX = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_SEND0 = 3'd3,
    ST_SEND1 = 3'd4,
    ST_SEND2 = 3'd5
  } state_e;

  function automatic logic is_enabled_state(input state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/report_tx.sv
// Byte serialiser for the 3-byte status report: snapshots PC and cycle count on
// start, then presents one byte at a time under a valid/ready handshake.
module report_tx
  import debug_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  pc,
  input  logic [15:0] count,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        xfer,
  output logic        done
);

  // Handshake: a byte moves in any cycle with tx_valid=1 and tx_ready=1; while
  // tx_ready=0 the presented byte and tx_valid are held unchanged.
  logic [7:0]  pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    xfer    = valid_q && tx_ready;
    done    = xfer && (idx_q == REPORT_LAST_IDX);
    if (start) begin
      pc_d    = {1'b0, pc};
      cnt_d   = count;
      idx_d   = 2'd0;
      valid_d = 1'b1;
    end else if (xfer) begin
      if (done) begin
        idx_d   = 2'd0;
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= 8'h00;
      cnt_q   <= 16'h0000;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Output byte depends only on flops, so tx_data/tx_valid have no input paths.
  always_comb begin
    tx_data = 8'h00;
    if (valid_q) begin
      case (idx_q)
        2'd0:    tx_data = pc_q;
        2'd1:    tx_data = cnt_q[15:8];
        2'd2:    tx_data = cnt_q[7:0];
        default: tx_data = 8'h00;
      endcase
    end
  end

  assign tx_valid = valid_q;

endmodule

// File: rtl/debug_unit.sv
// Host-controlled run/step/halt controller for the pipeline, with a cycle
// counter and a serialised PC/count report sent back over the host link.
module debug_unit
  import debug_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [6:0]  pc_in,
  input  logic        pipe_halt,
  output logic        pipe_enable,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] cycle_count,
  output logic        busy,
  output state_e      dbg_state
);

  state_e      state_q, state_d;
  logic        pipe_en_q, pipe_en_d;
  logic [15:0] count_q, count_d;
  logic        start;
  logic        xfer;
  logic        done;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            CMD_CONT:   state_d = ST_RUN;
            CMD_STEP:   state_d = ST_STEP;
            CMD_REPORT: begin
              state_d = ST_SEND0;
              start   = 1'b1;
            end
            default:    state_d = ST_IDLE;
          endcase
        end
      end
      ST_RUN: begin
        // Halt and 'h' together still produce a single stop and one report.
        if (pipe_halt || (rx_valid && (rx_data == CMD_HALT))) begin
          state_d = ST_SEND0;
          start   = 1'b1;
        end
      end
      ST_STEP: begin
        state_d = ST_SEND0;
        start   = 1'b1;
      end
      ST_SEND0: if (xfer) state_d = ST_SEND1;
      ST_SEND1: if (xfer) state_d = ST_SEND2;
      ST_SEND2: if (done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // The snapshot must include the increment of the final enabled cycle.
  always_comb begin
    pipe_en_d = is_enabled_state(state_d);
    count_d   = count_q + {15'd0, pipe_en_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pipe_en_q <= 1'b0;
      count_q   <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pipe_en_q <= pipe_en_d;
      count_q   <= count_d;
    end
  end

  report_tx u_report_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pc       (pc_in),
    .count    (count_d),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .xfer     (xfer),
    .done     (done)
  );

  assign pipe_enable = pipe_en_q;
  assign cycle_count = count_q;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state   = state_q;

endmodule
